// File: rtl/fifo_sector_drain.sv
// Drains the camera byte FIFO into fixed-size sectors on a valid/ready byte stream, one byte in flight.
// Optional sector padding on FLUSH is built when FIFO_SECTOR_DRAIN_PAD_EN is defined.
module fifo_sector_drain #(
  parameter int          SECT_BYTES = 512,
  parameter int          CNT_W      = 10,
  parameter logic [7:0]  PAD_BYTE   = 8'h00
) (
  input  logic        CLK,
  input  logic        RESET_N,
`ifdef FIFO_SECTOR_DRAIN_PAD_EN
  input  logic        i_FLUSH,
`endif
  input  logic        i_START,
  input  logic        i_ABORT,
  input  logic [15:0] i_NUM_SECT,
  input  logic        i_FIFO_EMPTY,
  input  logic        i_FIFO_FULL,
  output logic        o_FIFO_REN,
  input  logic [7:0]  i_FIFO_RDAT,
  input  logic        i_FIFO_RDAT_EN,
  output logic [7:0]  o_OUT_DAT,
  output logic        o_OUT_VALID,
  input  logic        i_OUT_READY,
  output logic        o_SECT_DONE,
  output logic [15:0] o_SECT_CNT,
  output logic        o_BUSY,
  output logic        o_DONE,
  output logic        o_OVF
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, XFER, SEND, FIN} state_t;

  state_t             r_state, w_nxt;
  logic [CNT_W-1:0]   r_byte_cnt;
  logic [15:0]        r_num, r_sect_cnt;
  logic [7:0]         r_out_dat;
  logic               r_out_valid, r_ovf;
  logic               w_flush, w_ren, w_pad_load, w_abort, w_last;
  logic [15:0]        w_sect_inc;

`ifdef FIFO_SECTOR_DRAIN_PAD_EN
  assign w_flush = i_FLUSH;
`else
  assign w_flush = 1'b0;
`endif

  assign w_abort    = i_ABORT && (r_state != IDLE);
  assign w_last     = (r_byte_cnt == CNT_W'(SECT_BYTES - 1));
  assign w_sect_inc = r_sect_cnt + 16'd1;

  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) r_state <= IDLE;
    else          r_state <= w_nxt;

  always_comb begin
    w_nxt      = r_state;
    w_ren      = 1'b0;
    w_pad_load = 1'b0;
    case (r_state)
      IDLE: if (i_START) w_nxt = (i_NUM_SECT == 16'd0) ? FIN : REQ;
      REQ: begin
        if (!i_FIFO_EMPTY) begin
          w_ren = 1'b1;
          w_nxt = WAIT;
        end else if (w_flush) begin
          // A partial sector is padded out; an empty one ends the transfer.
          if (r_byte_cnt != '0) begin
            w_pad_load = 1'b1;
            w_nxt      = XFER;
          end else begin
            w_nxt = FIN;
          end
        end
      end
      WAIT: if (i_FIFO_RDAT_EN) w_nxt = XFER;
      XFER: if (i_OUT_READY) w_nxt = w_last ? SEND : REQ;
      SEND: w_nxt = (w_sect_inc == r_num) ? FIN : REQ;
      FIN:  w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
    if (w_abort) begin
      w_nxt      = IDLE;
      w_ren      = 1'b0;
      w_pad_load = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_num       <= '0;
      r_sect_cnt  <= '0;
      r_byte_cnt  <= '0;
      r_out_dat   <= 8'h00;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      if (r_state == IDLE && i_START) begin
        r_num      <= i_NUM_SECT;
        r_sect_cnt <= '0;
        r_byte_cnt <= '0;
        r_ovf      <= 1'b0;
      end else if (r_state != IDLE && i_FIFO_FULL) begin
        r_ovf <= 1'b1;
      end
      if (w_abort) begin
        r_out_valid <= 1'b0;
      end else begin
        case (r_state)
          REQ: if (w_pad_load) begin
            r_out_dat   <= PAD_BYTE;
            r_out_valid <= 1'b1;
          end
          WAIT: if (i_FIFO_RDAT_EN) begin
            r_out_dat   <= i_FIFO_RDAT;
            r_out_valid <= 1'b1;
          end
          XFER: if (i_OUT_READY) begin
            r_out_valid <= 1'b0;
            r_byte_cnt  <= r_byte_cnt + 1'b1;
          end
          SEND: begin
            r_sect_cnt <= w_sect_inc;
            r_byte_cnt <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_FIFO_REN  = w_ren;
  assign o_OUT_DAT   = r_out_dat;
  assign o_OUT_VALID = r_out_valid;
  assign o_SECT_DONE = (r_state == SEND) && !i_ABORT;
  assign o_DONE      = (r_state == FIN) && !i_ABORT;
  assign o_SECT_CNT  = r_sect_cnt;
  assign o_BUSY      = (r_state != IDLE);
  assign o_OVF       = r_ovf;

endmodule
